cond_flag_unit: RTL and testbench

//  Consumer side of the ALU flag interface. Holds the architectural NZCV flag

---
 rtl/cond_flag_unit.sv | 141 ++++++++++++++
 tb/tb_cond_flag_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// -----------------------------------------------------------------------------
// cond_flag_unit
//
// Holds the architectural NZCV flag register. It checks each instruction's
// 4-bit ARM condition field against the stored flags. It then gates the
// decoder's write strobes (PCS/RegW/MemW) into the PC, register-file and
// memory write enables.
//
// Parameters
//   PIPE_OUT  0: PCSrc/RegWrite/MemWrite/CondEx are combinational from the
//                current inputs.
//             1: the same four outputs are registered, with one cycle of
//                latency.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   Cond      in   4  instruction condition field [31:28]
//   ALUFlags  in   4  flags from the ALU, {V,C,N,Z} = [3],[2],[1],[0]
//   FlagW     in   2  [1]: write N,Z   [0]: write C,V
//   PCS       in   1  decoder: instruction writes PC
//   RegW      in   1  decoder: instruction writes register file
//   MemW      in   1  decoder: instruction writes memory
//   NoWrite   in   1  decoder: compare-class op, suppress RegWrite
//   stall     in   1  hold: no flag update, registered outputs hold
//   flush     in   1  kill current instruction: strobes 0, no flag update
//   PCSrc     out  1  gated PCS
//   RegWrite  out  1  gated RegW & ~NoWrite
//   MemWrite  out  1  gated MemW
//   CondEx    out  1  condition passed
//   Flags     out  4  stored flag register, same bit order as ALUFlags
// -----------------------------------------------------------------------------
module cond_flag_unit #(
    parameter bit PIPE_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       stall,
    input  logic       flush,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass;
    logic       ok;
    logic       pc_src_d, reg_write_d, mem_write_d;

    assign flag_v = flags_q[3];
    assign flag_c = flags_q[2];
    assign flag_n = flags_q[1];
    assign flag_z = flags_q[0];

    // The condition is evaluated against the stored flags only. An
    // instruction that also sets flags therefore sees the values left by
    // earlier instructions. There is no bypass from ALUFlags.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;  // 1111 is unsupported: never execute
        endcase
    end

    // Reset is included so that no write strobe escapes while reset is held.
    // This covers the combinational output path as well.
    assign ok          = cond_pass & ~flush & ~reset;
    assign pc_src_d    = PCS & ok;
    assign reg_write_d = RegW & ~NoWrite & ok;
    assign mem_write_d = MemW & ok;

    // The two flag halves load independently. FlagW=2'b10 keeps C and V.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (ok && !stall) begin
            if (FlagW[1]) flags_q[1:0] <= ALUFlags[1:0];
            if (FlagW[0]) flags_q[3:2] <= ALUFlags[3:2];
        end
    end

    assign Flags = flags_q;

    generate
        if (PIPE_OUT) begin : g_pipe
            logic pc_src_q, reg_write_q, mem_write_q, cond_ex_q;

            // flush beats stall. The gated values are already 0 under flush,
            // so loading them on (flush | ~stall) clears the registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_src_q    <= 1'b0;
                    reg_write_q <= 1'b0;
                    mem_write_q <= 1'b0;
                    cond_ex_q   <= 1'b0;
                end else if (flush || !stall) begin
                    pc_src_q    <= pc_src_d;
                    reg_write_q <= reg_write_d;
                    mem_write_q <= mem_write_d;
                    cond_ex_q   <= ok;
                end
            end

            assign PCSrc    = pc_src_q;
            assign RegWrite = reg_write_q;
            assign MemWrite = mem_write_q;
            assign CondEx   = cond_ex_q;
        end else begin : g_comb
            assign PCSrc    = pc_src_d;
            assign RegWrite = reg_write_d;
            assign MemWrite = mem_write_d;
            assign CondEx   = cond_pass;
        end
    endgenerate

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit. Two instances share all inputs: c_* is the
// combinational build (PIPE_OUT=0) and r_* is the registered build
// (PIPE_OUT=1). Inputs change 1 ns after a rising edge. Outputs are sampled
// a few ns later, before the next rising edge.
module tb_cond_flag_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, stall, flush;

    logic       c_pc, c_rw, c_mw, c_ce;
    logic [3:0] c_flags;
    logic       r_pc, r_rw, r_mw, r_ce;
    logic [3:0] r_flags;

    int checks = 0;
    int errors = 0;

    cond_flag_unit #(.PIPE_OUT(1'b0)) u_comb (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .stall(stall), .flush(flush),
        .PCSrc(c_pc), .RegWrite(c_rw), .MemWrite(c_mw), .CondEx(c_ce),
        .Flags(c_flags)
    );

    cond_flag_unit #(.PIPE_OUT(1'b1)) u_pipe (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .stall(stall), .flush(flush),
        .PCSrc(r_pc), .RegWrite(r_rw), .MemWrite(r_mw), .CondEx(r_ce),
        .Flags(r_flags)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        Cond = 4'b1111; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic write_flags(input logic [3:0] v);
        idle;
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = v;
        tick;
        idle;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        idle;
        #2;
        checks++;
        if (c_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags_c got %b want 0000", c_flags); end
        checks++;
        if ({r_pc, r_rw, r_mw, r_ce, r_flags} !== 8'h00) begin
            errors++; $display("FAIL reset_pipe got %b want 00000000", {r_pc, r_rw, r_mw, r_ce, r_flags});
        end
        tick;
        reset = 1'b0;
        write_flags(4'b1111);
        #2;
        checks++;
        if (c_flags !== 4'b1111) begin errors++; $display("FAIL preset_flags got %b want 1111", c_flags); end
        // asynchronous reset in the middle of a cycle
        reset = 1'b1;
        #1;
        checks++;
        if ({c_flags, r_flags} !== 8'h00) begin errors++; $display("FAIL async_reset_flags got %b want 00000000", {c_flags, r_flags}); end
        checks++;
        if ({r_pc, r_rw, r_mw, r_ce} !== 4'b0000) begin errors++; $display("FAIL async_reset_pipe got %b want 0000", {r_pc, r_rw, r_mw, r_ce}); end
        Cond = 4'b0000; RegW = 1'b1;
        #1;
        checks++;
        if ({c_ce, c_rw} !== 2'b00) begin errors++; $display("FAIL reset_eq got ce/rw %b want 00", {c_ce, c_rw}); end
        Cond = 4'b1110;
        #1;
        checks++;
        if ({c_ce, c_rw} !== 2'b10) begin errors++; $display("FAIL reset_al got ce/rw %b want 10", {c_ce, c_rw}); end
        tick;
        checks++;
        if ({r_rw, r_ce} !== 2'b00) begin errors++; $display("FAIL reset_pipe_hold got rw/ce %b want 00", {r_rw, r_ce}); end
        reset = 1'b0;
        idle;
    endtask

    task automatic test_write_eq;
        write_flags(4'b0001);
        #2;
        checks++;
        if ({c_flags, r_flags} !== 8'b0001_0001) begin errors++; $display("FAIL write_z got %b want 00010001", {c_flags, r_flags}); end
        Cond = 4'b0000; RegW = 1'b1;
        #2;
        checks++;
        if ({c_ce, c_rw} !== 2'b11) begin errors++; $display("FAIL eq_taken got ce/rw %b want 11", {c_ce, c_rw}); end
        tick;
        checks++;
        if ({r_ce, r_rw} !== 2'b11) begin errors++; $display("FAIL eq_taken_pipe got ce/rw %b want 11", {r_ce, r_rw}); end
        Cond = 4'b0001;
        #2;
        checks++;
        if ({c_ce, c_rw} !== 2'b00) begin errors++; $display("FAIL ne_blocked got ce/rw %b want 00", {c_ce, c_rw}); end
        tick;
        checks++;
        if ({r_ce, r_rw} !== 2'b00) begin errors++; $display("FAIL ne_blocked_pipe got ce/rw %b want 00", {r_ce, r_rw}); end
        idle;
    endtask

    task automatic test_half_writes;
        write_flags(4'b0000);
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1110;
        tick;
        checks++;
        if ({c_flags, r_flags} !== 8'b0010_0010) begin errors++; $display("FAIL half_nz got %b want 00100010", {c_flags, r_flags}); end
        FlagW = 2'b01; ALUFlags = 4'b0100;
        tick;
        checks++;
        if ({c_flags, r_flags} !== 8'b0110_0110) begin errors++; $display("FAIL half_cv got %b want 01100110", {c_flags, r_flags}); end
        idle;
    endtask

    task automatic test_signed_conds;
        write_flags(4'b0010);
        MemW = 1'b1;
        Cond = 4'b1011;
        #2;
        checks++;
        if ({c_ce, c_mw} !== 2'b11) begin errors++; $display("FAIL lt got ce/mw %b want 11", {c_ce, c_mw}); end
        Cond = 4'b1010;
        #2;
        checks++;
        if ({c_ce, c_mw} !== 2'b00) begin errors++; $display("FAIL ge got ce/mw %b want 00", {c_ce, c_mw}); end
        Cond = 4'b1100;
        #2;
        checks++;
        if ({c_ce, c_mw} !== 2'b00) begin errors++; $display("FAIL gt got ce/mw %b want 00", {c_ce, c_mw}); end
        Cond = 4'b1101;
        #2;
        checks++;
        if ({c_ce, c_mw} !== 2'b11) begin errors++; $display("FAIL le got ce/mw %b want 11", {c_ce, c_mw}); end
        tick;
        checks++;
        if ({r_ce, r_mw} !== 2'b11) begin errors++; $display("FAIL le_pipe got ce/mw %b want 11", {r_ce, r_mw}); end
        idle;
    endtask

    // Full condition sweep against a hand-computed pass mask (bit i = Cond i).
    task automatic test_cond_table(input logic [3:0] fl, input logic [15:0] mask);
        write_flags(fl);
        PCS = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Cond = i[3:0];
            #1;
            checks++;
            if ({c_ce, c_pc} !== {2{mask[i]}}) begin
                errors++;
                $display("FAIL cond_table flags=%b cond=%b got ce/pc %b want %b", fl, Cond, {c_ce, c_pc}, {2{mask[i]}});
            end
        end
        idle;
    endtask

    task automatic test_nowrite;
        write_flags(4'b0000);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1; NoWrite = 1'b1;
        #2;
        checks++;
        if ({c_ce, c_rw} !== 2'b10) begin errors++; $display("FAIL nowrite got ce/rw %b want 10", {c_ce, c_rw}); end
        tick;
        checks++;
        if (c_flags !== 4'b1111) begin errors++; $display("FAIL nowrite_flags got %b want 1111", c_flags); end
        checks++;
        if ({r_ce, r_rw} !== 2'b10) begin errors++; $display("FAIL nowrite_pipe got ce/rw %b want 10", {r_ce, r_rw}); end
        idle;
    endtask

    task automatic test_stall_flush;
        // Flags = 1111 from the previous scenario.
        Cond = 4'b1110; PCS = 1'b1;
        tick;
        checks++;
        if (r_pc !== 1'b1) begin errors++; $display("FAIL pre_stall_pc got %b want 1", r_pc); end
        stall = 1'b1; PCS = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0101;
        tick;
        checks++;
        if (c_flags !== 4'b1111) begin errors++; $display("FAIL stall_flags got %b want 1111", c_flags); end
        checks++;
        if (r_pc !== 1'b1) begin errors++; $display("FAIL stall_hold_pc got %b want 1", r_pc); end
        stall = 1'b0; flush = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        #2;
        checks++;
        if ({c_pc, c_rw, c_mw} !== 3'b000) begin errors++; $display("FAIL flush_comb got %b want 000", {c_pc, c_rw, c_mw}); end
        tick;
        checks++;
        if (c_flags !== 4'b1111) begin errors++; $display("FAIL flush_flags got %b want 1111", c_flags); end
        checks++;
        if ({r_pc, r_rw, r_mw, r_ce} !== 4'b0000) begin errors++; $display("FAIL flush_pipe got %b want 0000", {r_pc, r_rw, r_mw, r_ce}); end
        flush = 1'b0; FlagW = 2'b00;
        tick;
        checks++;
        if ({r_pc, r_rw, r_mw} !== 3'b111) begin errors++; $display("FAIL reload_pipe got %b want 111", {r_pc, r_rw, r_mw}); end
        stall = 1'b1; flush = 1'b1; FlagW = 2'b11;
        #2;
        checks++;
        if ({c_pc, c_rw, c_mw} !== 3'b000) begin errors++; $display("FAIL stall_flush_comb got %b want 000", {c_pc, c_rw, c_mw}); end
        tick;
        checks++;
        if ({r_pc, r_rw, r_mw, r_ce} !== 4'b0000) begin errors++; $display("FAIL stall_flush_pipe got %b want 0000", {r_pc, r_rw, r_mw, r_ce}); end
        checks++;
        if (c_flags !== 4'b1111) begin errors++; $display("FAIL stall_flush_flags got %b want 1111", c_flags); end
        // latency of the registered build
        idle;
        Cond = 4'b1110; PCS = 1'b1;
        #2;
        checks++;
        if ({c_pc, r_pc} !== 2'b10) begin errors++; $display("FAIL latency_before got c/r %b want 10", {c_pc, r_pc}); end
        tick;
        idle;
        checks++;
        if (r_pc !== 1'b1) begin errors++; $display("FAIL latency_one got %b want 1", r_pc); end
        tick;
        checks++;
        if (r_pc !== 1'b0) begin errors++; $display("FAIL latency_two got %b want 0", r_pc); end
        // the same write goes through once stall and flush are released
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0101;
        tick;
        checks++;
        if ({c_flags, r_flags} !== 8'b0101_0101) begin errors++; $display("FAIL release_write got %b want 01010101", {c_flags, r_flags}); end
        idle;
    endtask

    task automatic test_back_to_back;
        write_flags(4'b0001);
        // EQ passes on the old Z=1 while also clearing Z
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1'b1;
        #2;
        checks++;
        if ({c_ce, c_rw} !== 2'b11) begin errors++; $display("FAIL b2b_old_flags got ce/rw %b want 11", {c_ce, c_rw}); end
        tick;
        checks++;
        if ({c_flags, c_ce, c_rw} !== 6'b0000_00) begin errors++; $display("FAIL b2b_updated got %b want 000000", {c_flags, c_ce, c_rw}); end
        // the condition now fails, so this write must be dropped
        ALUFlags = 4'b0001;
        tick;
        checks++;
        if (c_flags !== 4'b0000) begin errors++; $display("FAIL b2b_blocked_write got %b want 0000", c_flags); end
        idle;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset;
        test_write_eq;
        test_half_writes;
        test_signed_conds;
        test_cond_table(4'b0010, 16'h6A9A);
        test_cond_table(4'b0001, 16'h66A9);
        test_cond_table(4'b0100, 16'h55A6);
        test_cond_table(4'b1000, 16'h6A6A);
        test_cond_table(4'b1111, 16'h6655);
        test_nowrite;
        test_stall_flush;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
